// File: rtl/issue_commit_table_if.sv
// Issue / commit / retire bundle for the issue_commit_table scoreboard.
// The master drives issue requests and commit reports; the table is the slave.
interface issue_commit_table_if #(
  parameter int NUM_ENTRY   = 8,
  parameter int WIDTH_INDEX = 6,
  parameter int NUM_SRC     = 3,
  parameter int NUM_LANE    = 4
);
  localparam int WN = $clog2(NUM_ENTRY);
  localparam int WI = WIDTH_INDEX + 1;

  logic                  I_Req;
  logic                  I_Dst_V;
  logic [WI-1:0]         I_Dst_Idx;
  logic [NUM_SRC-1:0]    I_Src_V;
  logic [NUM_SRC*WI-1:0] I_Src_Idx;
  logic [NUM_LANE-1:0]   I_En_Lane;
  logic                  O_Ack;
  logic                  O_Stall;
  logic [WN-1:0]         O_Issue_No;

  logic                  I_Commit_Req;
  logic [WN-1:0]         I_Commit_No;
  logic [NUM_LANE-1:0]   I_Commit_Lane;
  logic                  O_Commit_Err;

  logic                  O_Retire;
  logic [WN-1:0]         O_Retire_No;
  logic                  O_Full;
  logic                  O_Empty;
  logic [WN:0]           O_Count;

  modport master (
    output I_Req, I_Dst_V, I_Dst_Idx, I_Src_V, I_Src_Idx, I_En_Lane,
    output I_Commit_Req, I_Commit_No, I_Commit_Lane,
    input  O_Ack, O_Stall, O_Issue_No, O_Commit_Err,
    input  O_Retire, O_Retire_No, O_Full, O_Empty, O_Count
  );

  modport slave (
    input  I_Req, I_Dst_V, I_Dst_Idx, I_Src_V, I_Src_Idx, I_En_Lane,
    input  I_Commit_Req, I_Commit_No, I_Commit_Lane,
    output O_Ack, O_Stall, O_Issue_No, O_Commit_Err,
    output O_Retire, O_Retire_No, O_Full, O_Empty, O_Count
  );
endinterface

// File: rtl/issue_commit_table.sv
// In-order issue/commit scoreboard: a circular table of in-flight instructions
// that blocks issue on RAW/WAW register hazards, collects per-lane commit
// reports and retires entries from the head one per cycle.
module issue_commit_table #(
  parameter int NUM_ENTRY   = 8,
  parameter int WIDTH_INDEX = 6,
  parameter int NUM_SRC     = 3,
  parameter int NUM_LANE    = 4
) (
  input logic                clock,
  input logic                reset,
  issue_commit_table_if.slave bus
);
  localparam int WN = $clog2(NUM_ENTRY);
  localparam int WI = WIDTH_INDEX + 1;
  localparam logic [WN:0] FULL_CNT = (WN+1)'(NUM_ENTRY);

  logic [NUM_ENTRY-1:0] ent_v;
  logic [NUM_ENTRY-1:0] ent_dst_v;
  logic [NUM_ENTRY-1:0] ent_commit;
  logic [WI-1:0]        ent_dst_idx   [NUM_ENTRY];
  logic [NUM_LANE-1:0]  ent_en_lane   [NUM_ENTRY];
  logic [NUM_LANE-1:0]  ent_en_commit [NUM_ENTRY];

  logic [WN-1:0] head;
  logic [WN-1:0] tail;
  logic [WN:0]   count;
  logic          retire_q;
  logic [WN-1:0] retire_no_q;
  logic          commit_err_q;

  logic                raw_hit;
  logic                waw_hit;
  logic                full;
  logic                ack;
  logic                retire;
  logic [NUM_LANE-1:0] commit_upd;

  assign full   = (count == FULL_CNT);
  assign ack    = bus.I_Req & ~raw_hit & ~waw_hit & ~full;
  assign retire = ent_v[head] & ent_commit[head];
  assign commit_upd = ent_en_commit[bus.I_Commit_No]
                    | (bus.I_Commit_Lane & ent_en_lane[bus.I_Commit_No]);

  // Hazard search over entries still waiting on commits, pre-edge state only
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      if (ent_v[e] && !ent_commit[e] && ent_dst_v[e]) begin
        if (bus.I_Dst_V && (bus.I_Dst_Idx == ent_dst_idx[e])) waw_hit = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
          if (bus.I_Src_V[k] && (bus.I_Src_Idx[k*WI +: WI] == ent_dst_idx[e]))
            raw_hit = 1'b1;
        end
      end
    end
  end

  // Table state: commit update, in-order retire, tail allocation, occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_v        <= '0;
      ent_dst_v    <= '0;
      ent_commit   <= '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        ent_dst_idx[e]   <= '0;
        ent_en_lane[e]   <= '0;
        ent_en_commit[e] <= '0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_q     <= 1'b0;
      retire_no_q  <= '0;
      commit_err_q <= 1'b0;
    end else begin
      commit_err_q <= 1'b0;
      retire_q     <= 1'b0;

      if (bus.I_Commit_Req) begin
        if (ent_v[bus.I_Commit_No]) begin
          ent_en_commit[bus.I_Commit_No] <= commit_upd;
          if (commit_upd == ent_en_lane[bus.I_Commit_No])
            ent_commit[bus.I_Commit_No] <= 1'b1;
        end else begin
          commit_err_q <= 1'b1;
        end
      end

      if (retire) begin
        ent_v[head] <= 1'b0;
        head        <= head + 1'b1;
        retire_q    <= 1'b1;
        retire_no_q <= head;
      end

      // The tail is never valid when ack is possible, so this cannot collide
      // with the commit or retire writes above.
      if (ack) begin
        ent_v[tail]         <= 1'b1;
        ent_dst_v[tail]     <= bus.I_Dst_V;
        ent_dst_idx[tail]   <= bus.I_Dst_Idx;
        ent_en_lane[tail]   <= bus.I_En_Lane;
        ent_en_commit[tail] <= '0;
        ent_commit[tail]    <= (bus.I_En_Lane == '0);
        tail                <= tail + 1'b1;
      end

      if (ack && !retire)      count <= count + 1'b1;
      else if (!ack && retire) count <= count - 1'b1;
    end
  end

  assign bus.O_Ack        = ack;
  assign bus.O_Stall      = bus.I_Req & ~ack;
  assign bus.O_Issue_No   = tail;
  assign bus.O_Commit_Err = commit_err_q;
  assign bus.O_Retire     = retire_q;
  assign bus.O_Retire_No  = retire_no_q;
  assign bus.O_Full       = full;
  assign bus.O_Empty      = (count == '0);
  assign bus.O_Count      = count;
endmodule

// File: tb/tb_issue_commit_table.sv
// Directed bench for issue_commit_table: hazards, lane commits, retire,
// full/wrap behaviour, commit errors and reset.
module tb_issue_commit_table;
  localparam int NE = 8;
  localparam int WX = 6;
  localparam int NS = 3;
  localparam int NL = 4;
  localparam int WI = WX + 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  issue_commit_table_if #(.NUM_ENTRY(NE), .WIDTH_INDEX(WX), .NUM_SRC(NS), .NUM_LANE(NL)) bus ();

  issue_commit_table #(.NUM_ENTRY(NE), .WIDTH_INDEX(WX), .NUM_SRC(NS), .NUM_LANE(NL)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.I_Req         = 1'b0;
    bus.I_Dst_V       = 1'b0;
    bus.I_Dst_Idx     = '0;
    bus.I_Src_V       = '0;
    bus.I_Src_Idx     = '0;
    bus.I_En_Lane     = '0;
    bus.I_Commit_Req  = 1'b0;
    bus.I_Commit_No   = '0;
    bus.I_Commit_Lane = '0;
  endtask

  task automatic issue(input logic dv, input logic [WI-1:0] di,
                       input logic [NS-1:0] sv, input logic [NS*WI-1:0] si,
                       input logic [NL-1:0] en);
    bus.I_Req     = 1'b1;
    bus.I_Dst_V   = dv;
    bus.I_Dst_Idx = di;
    bus.I_Src_V   = sv;
    bus.I_Src_Idx = si;
    bus.I_En_Lane = en;
  endtask

  task automatic commit(input logic [2:0] no, input logic [NL-1:0] lane);
    bus.I_Commit_Req  = 1'b1;
    bus.I_Commit_No   = no;
    bus.I_Commit_Lane = lane;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    tick();
    tick();

    // reset state
    chk("rst_empty",  32'(bus.O_Empty), 1);
    chk("rst_full",   32'(bus.O_Full), 0);
    chk("rst_count",  32'(bus.O_Count), 0);
    chk("rst_issno",  32'(bus.O_Issue_No), 0);
    chk("rst_retire", 32'(bus.O_Retire), 0);
    chk("rst_err",    32'(bus.O_Commit_Err), 0);
    rst = 1'b0;

    // RAW: dst=5 then src0=5 stalls until all lanes of entry 0 commit
    issue(1'b1, 7'd5, 3'b000, '0, 4'b1111);
    settle();
    chk("raw_first_ack", 32'(bus.O_Ack), 1);
    chk("raw_first_no",  32'(bus.O_Issue_No), 0);
    tick();
    issue(1'b0, 7'd0, 3'b001, {7'd0, 7'd0, 7'd5}, 4'b1111);
    commit(3'd0, 4'b1111);
    settle();
    chk("raw_stall",       32'(bus.O_Stall), 1);
    chk("raw_stall_noack", 32'(bus.O_Ack), 0);
    tick();
    bus.I_Commit_Req = 1'b0;
    settle();
    chk("raw_clear_ack", 32'(bus.O_Ack), 1);
    chk("raw_clear_no",  32'(bus.O_Issue_No), 1);
    tick();
    idle();
    chk("raw_retire",    32'(bus.O_Retire), 1);
    chk("raw_retire_no", 32'(bus.O_Retire_No), 0);
    chk("raw_count",     32'(bus.O_Count), 1);

    // WAW: dst=5 twice stalls; 5 versus 69 differ only in the MSb
    do_reset();
    issue(1'b1, 7'd5, 3'b000, '0, 4'b1111);
    tick();
    issue(1'b1, 7'd5, 3'b000, '0, 4'b1111);
    settle();
    chk("waw_stall", 32'(bus.O_Stall), 1);
    issue(1'b1, 7'd69, 3'b010, {7'd0, 7'd69, 7'd0}, 4'b1111);
    settle();
    chk("waw_msb_ack", 32'(bus.O_Ack), 1);
    tick();
    idle();
    chk("waw_count", 32'(bus.O_Count), 2);

    // Partial lane commits: en_lane=1011, reports 0011 then 1000
    do_reset();
    issue(1'b0, 7'd0, 3'b000, '0, 4'b1011);
    tick();
    idle();
    commit(3'd0, 4'b0011);
    tick();
    idle();
    tick();
    chk("lane_partial_noretire", 32'(bus.O_Retire), 0);
    commit(3'd0, 4'b1000);
    tick();
    idle();
    chk("lane_commit_edge_noretire", 32'(bus.O_Retire), 0);
    tick();
    chk("lane_retire",    32'(bus.O_Retire), 1);
    chk("lane_retire_no", 32'(bus.O_Retire_No), 0);
    chk("lane_empty",     32'(bus.O_Empty), 1);
    tick();
    chk("lane_retire_pulse", 32'(bus.O_Retire), 0);

    // Fill, full blocks issue even with a same-cycle retire, then wrap
    do_reset();
    for (int i = 0; i < NE; i++) begin
      issue(1'b0, 7'd0, 3'b000, '0, 4'b0001);
      settle();
      chk("fill_no", 32'(bus.O_Issue_No), 32'(i));
      tick();
    end
    idle();
    chk("fill_full",  32'(bus.O_Full), 1);
    chk("fill_count", 32'(bus.O_Count), 8);
    commit(3'd0, 4'b0001);
    tick();
    idle();
    issue(1'b0, 7'd0, 3'b000, '0, 4'b0001);
    settle();
    chk("full_stall", 32'(bus.O_Stall), 1);
    chk("full_noack", 32'(bus.O_Ack), 0);
    tick();
    chk("full_retire",    32'(bus.O_Retire), 1);
    chk("full_count_dec", 32'(bus.O_Count), 7);
    chk("full_ack_after", 32'(bus.O_Ack), 1);
    chk("full_wrap_no",   32'(bus.O_Issue_No), 0);
    tick();
    idle();
    chk("full_refill_count", 32'(bus.O_Count), 8);
    chk("full_tail_next",    32'(bus.O_Issue_No), 1);

    // Commit to an invalid entry, then a zero-lane issue that retires alone
    do_reset();
    commit(3'd3, 4'b1111);
    tick();
    idle();
    chk("err_pulse", 32'(bus.O_Commit_Err), 1);
    chk("err_count", 32'(bus.O_Count), 0);
    chk("err_empty", 32'(bus.O_Empty), 1);
    tick();
    chk("err_pulse_end", 32'(bus.O_Commit_Err), 0);
    issue(1'b1, 7'd9, 3'b000, '0, 4'b0000);
    tick();
    idle();
    chk("nolane_count", 32'(bus.O_Count), 1);
    tick();
    chk("nolane_retire",    32'(bus.O_Retire), 1);
    chk("nolane_retire_no", 32'(bus.O_Retire_No), 0);
    chk("nolane_empty",     32'(bus.O_Empty), 1);

    // Reset with three entries in flight plus a simultaneous issue and commit
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 7'd0, 3'b000, '0, 4'b1111);
      tick();
    end
    idle();
    chk("inflight_count", 32'(bus.O_Count), 3);
    issue(1'b0, 7'd0, 3'b000, '0, 4'b1111);
    commit(3'd0, 4'b1111);
    rst = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    chk("rst2_empty",  32'(bus.O_Empty), 1);
    chk("rst2_count",  32'(bus.O_Count), 0);
    chk("rst2_retire", 32'(bus.O_Retire), 0);
    chk("rst2_issno",  32'(bus.O_Issue_No), 0);
    tick();
    chk("rst2_no_late_retire", 32'(bus.O_Retire), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
